gp_lpddr5_cmd_encoder: RTL and testbench
========================================

GP_LPDDR5_CMD_ENCODER -- requirements
Module: gp_lpddr5_cmd_encoder

Interface
REQ-001 SHALL have parameter REFI_CYC, default 64: ck_t cycles from one REF on the bus until an auto-refresh becomes due.
REQ-002 SHALL have parameter ACT_REF_GAP, default 7: minimum ck_t cycles from an ACT first cycle to any REF.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: ports ck_t and ddr_reset_n.
REQ-004 ck_t  input  1  command clock; all state updates on posedge.
REQ-005 ddr_reset_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  command request valid.
REQ-007 req_ready  output  1  encoder can accept a request.
REQ-008 req_op  input  4  opcode, from the package enum.
REQ-009 req_arg  input  8  command argument (bank/row/column/MR field).
REQ-010 ca  output  7  CA bus; ca[0]..ca[6] drive CA0..CA6; codes below list CA0 first.
REQ-011 cs  output  1  chip select.
REQ-012 auto_ref  output  1  high during the cycle an auto-inserted REF is on the bus.
REQ-013 pd_active  output  1  high while the encoder is in power-down.
REQ-014 err  output  1  one-cycle pulse when an illegal opcode is accepted.

Function
REQ-015 A request is accepted when req_valid and req_ready are both high at a posedge; its first command cycle appears on ca/cs at the next posedge. ca and cs are registered.
REQ-016 req_ready is high only in IDLE, with no auto-refresh pending, and with ddr_reset_n high. At least one DES cycle occurs between consecutive commands.
REQ-017 DES/idle is cs=0, ca=0000000. Every command cycle drives cs=1 unless stated otherwise.
REQ-018 Encodings, one cycle each ("|" means concatenation, argument MSB first):
- ACT: 111|arg[3:0], then 110|arg[7:4].
- PRE: 0001111.
- REF: 0001110.
- WR16: 0011100 (CAS_WR), then 011|arg[3:0].
- RD16: 0011010 (CAS_RD), then 100|arg[3:0].
- MRW: 0001101, then 000100|arg[0].
- MRR: 0001100.
- PDE: 0000001.
- PDX: cs=0, ca=0000001.
REQ-019 The two cycles of a two-cycle command SHALL be on consecutive posedges with no DES between them.
REQ-020 FSM states: IDLE, CMD1, CMD2, GAP_WAIT, PD.
- IDLE -> CMD1 on accept.
- CMD1 -> CMD2 for two-cycle ops, otherwise -> IDLE.
- CMD2 -> IDLE.
- PDE: CMD1 -> PD.
- PD -> IDLE after PDX.
REQ-021 A REF, user or auto, issued while the ACT gap counter is nonzero SHALL wait in GAP_WAIT driving DES. The REF is emitted the cycle after the counter reaches 0, so it never appears within ACT_REF_GAP-1 cycles after the ACT first cycle.
REQ-022 The ACT gap counter loads ACT_REF_GAP-1 on the ACT first cycle, decrements to 0 and saturates there.
REQ-023 In PD: cs=0 and ca=0. Only OP_PDX is accepted; other ops keep req_ready low. pd_active=1 from the cycle after the PDE cycle through the PDX cycle.
REQ-024 An illegal opcode is accepted, emits no command (DES), and pulses err for 1 cycle.
REQ-025 An auto-refresh due in the same cycle as a request arrives takes priority; the request stays unaccepted (req_ready=0).

Reset
REQ-026 Asserting ddr_reset_n asynchronously forces these values, including mid-command (the command is aborted, the second cycle is never emitted):
- state IDLE; ca=0, cs=0;
- auto_ref=0, err=0, pd_active=0, req_ready=0;
- refresh timer and ACT gap counter cleared.
REQ-027 The first posedge after release SHALL find req_ready=1.

Configuration
REQ-028 Macro GP_LPDDR5_AUTO_REFRESH_EN compiles the auto-refresh feature in or out.
- Defined: a timer counts cycles since the last REF on the bus and is cleared by any REF. At REFI_CYC the auto-refresh is pending; the REF is inserted at the next IDLE, subject to REQ-021, with auto_ref=1. The timer is frozen in PD.
- Undefined: no timer; REF only on request; auto_ref tied 0.

Structure
REQ-029 Package gp_lpddr5_cmd_pkg SHALL hold:
- opcode enum: OP_ACT=1, OP_PRE=2, OP_REF=3, OP_WR16=4, OP_RD16=5, OP_MRW=6, OP_MRR=7, OP_PDE=8, OP_PDX=9;
- 7-bit CA code constants;
- FSM state typedef.
REQ-030 Sub-module gp_lpddr5_ref_timer holds the refresh timer and the pending flag.

Verification
REQ-031 ACT with arg=8'hA5 -> next two cycles ca=1110101 then 1101010, cs=1 both; then DES.
REQ-032 WR16 with arg=4'h3 -> 0011100 then 0110011 on consecutive cycles; RD16 likewise 0011010 then 100|arg.
REQ-033 REF requested 2 cycles after an ACT accept -> REF on the bus no earlier than 7 cycles after the ACT first cycle; DES in between.
REQ-034 AUTO_REFRESH_EN defined, REFI_CYC=64, no requests -> REF every 65 cycles with auto_ref=1; with continuous traffic, the REF-to-REF interval stays at or below 100 cycles.
REQ-035 PDE, then 20 idle cycles, then PDX -> 0000001 with cs=1; then cs=0; pd_active=1; PDX cycle cs=0, ca=0000001; RD16 offered during PD is not accepted.
REQ-036 ddr_reset_n asserted during the WR16 CAS_WR cycle -> ca=0, cs=0 immediately; WR16 second cycle never emitted; req_ready=1 at the first posedge after release.

Source files
------------

// File: rtl/gp_lpddr5_cmd_pkg.sv
// LPDDR5 command encoder shared definitions: opcodes, FSM states and CA codes.
// CA code constants are written CA0 first (leftmost bit = CA0); ca_pins()
// reorders such a code onto the ca[6:0] port, where ca[0] drives CA0.
package gp_lpddr5_cmd_pkg;

  typedef enum logic [3:0] {
    OP_ACT  = 4'd1,
    OP_PRE  = 4'd2,
    OP_REF  = 4'd3,
    OP_WR16 = 4'd4,
    OP_RD16 = 4'd5,
    OP_MRW  = 4'd6,
    OP_MRR  = 4'd7,
    OP_PDE  = 4'd8,
    OP_PDX  = 4'd9
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD1,
    ST_CMD2,
    ST_GAP_WAIT,
    ST_PD
  } state_e;

  localparam logic [6:0] CA_DES    = 7'b0000000;
  localparam logic [6:0] CA_PRE    = 7'b0001111;
  localparam logic [6:0] CA_REF    = 7'b0001110;
  localparam logic [6:0] CA_CAS_WR = 7'b0011100;
  localparam logic [6:0] CA_CAS_RD = 7'b0011010;
  localparam logic [6:0] CA_MRW1   = 7'b0001101;
  localparam logic [6:0] CA_MRR    = 7'b0001100;
  localparam logic [6:0] CA_PDE    = 7'b0000001;
  localparam logic [6:0] CA_PDX    = 7'b0000001;

  // Fixed headers of codes that carry argument bits in their tail
  localparam logic [2:0] CA_ACT1_HDR = 3'b111;
  localparam logic [2:0] CA_ACT2_HDR = 3'b110;
  localparam logic [2:0] CA_WR2_HDR  = 3'b011;
  localparam logic [2:0] CA_RD2_HDR  = 3'b100;
  localparam logic [5:0] CA_MRW2_HDR = 6'b000100;

  // Map a CA0-first code onto port order (bit i of the result drives CAi)
  function automatic logic [6:0] ca_pins(input logic [6:0] code);
    logic [6:0] pins;
    for (int i = 0; i < 7; i++) pins[i] = code[6 - i];
    return pins;
  endfunction

endpackage

// File: rtl/gp_lpddr5_ref_timer.sv
// Refresh interval timer: counts ck_t cycles since the last REF on the bus,
// saturating at REFI_CYC, where the auto-refresh becomes pending.
// Only built into the encoder when GP_LPDDR5_AUTO_REFRESH_EN is defined.
module gp_lpddr5_ref_timer #(
  parameter int REFI_CYC = 64
) (
  input  logic ck_t,
  input  logic ddr_reset_n,
  input  logic clear,
  input  logic freeze,
  output logic pending
);

  localparam int TW = $clog2(REFI_CYC + 1);

  logic [TW-1:0] cnt;

  // Count up to the interval, hold there until a REF clears it; hold in power-down
  always_ff @(posedge ck_t or negedge ddr_reset_n) begin
    if (!ddr_reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!freeze && (cnt != TW'(REFI_CYC))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign pending = (cnt == TW'(REFI_CYC));

endmodule

// File: rtl/gp_lpddr5_cmd_encoder.sv
// LPDDR5 command encoder: turns single requests into registered CA/CS
// command cycles, enforces the ACT-to-REF gap and handles power-down.
// Optional auto-refresh insertion is compiled in by GP_LPDDR5_AUTO_REFRESH_EN.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | DES on the bus, request may be accepted
// ST_CMD1     | first command cycle on the bus
// ST_CMD2     | second cycle of ACT/WR16/RD16/MRW on the bus
// ST_GAP_WAIT | REF held back (DES) until the ACT gap counter has expired
// ST_PD       | power-down, bus held at DES, only PDX accepted
module gp_lpddr5_cmd_encoder
  import gp_lpddr5_cmd_pkg::*;
#(
  parameter int REFI_CYC    = 64,
  parameter int ACT_REF_GAP = 7
) (
  input  logic       ck_t,
  input  logic       ddr_reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [7:0] req_arg,
  output logic [6:0] ca,
  output logic       cs,
  output logic       auto_ref,
  output logic       pd_active,
  output logic       err
);

  localparam int GW = (ACT_REF_GAP > 1) ? $clog2(ACT_REF_GAP) : 1;

  state_e        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [7:0]    arg_q, arg_d;
  logic          wait_auto_q, wait_auto_d;
  logic [GW-1:0] gap_q;
  logic [6:0]    code_d;
  logic          cs_d, auto_d, err_d, pd_d;
  logic          issue_ref, load_gap;
  logic          ref_pending;

`ifdef GP_LPDDR5_AUTO_REFRESH_EN
  gp_lpddr5_ref_timer #(.REFI_CYC(REFI_CYC)) u_ref_timer (
    .ck_t        (ck_t),
    .ddr_reset_n (ddr_reset_n),
    .clear       (issue_ref),
    .freeze      (state_q == ST_PD),
    .pending     (ref_pending)
  );
`else
  logic unused_refi_cfg;
  assign unused_refi_cfg = (REFI_CYC > 0);
  assign ref_pending     = 1'b0;
`endif

  // A pending auto-refresh blocks new requests; in power-down only PDX gets through
  assign req_ready = ddr_reset_n &&
                     (((state_q == ST_IDLE) && !ref_pending) ||
                      ((state_q == ST_PD) && (req_op == OP_PDX)));

  // Next state and next bus word
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    arg_d       = arg_q;
    wait_auto_d = wait_auto_q;
    code_d      = CA_DES;
    cs_d        = 1'b0;
    auto_d      = 1'b0;
    err_d       = 1'b0;
    pd_d        = 1'b0;
    issue_ref   = 1'b0;
    load_gap    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ref_pending) begin
          op_d        = OP_REF;
          wait_auto_d = 1'b1;
          if (gap_q == '0) begin
            code_d    = CA_REF;
            cs_d      = 1'b1;
            auto_d    = 1'b1;
            issue_ref = 1'b1;
            state_d   = ST_CMD1;
          end else begin
            state_d = ST_GAP_WAIT;
          end
        end else if (req_valid) begin
          op_d        = req_op;
          arg_d       = req_arg;
          wait_auto_d = 1'b0;
          state_d     = ST_CMD1;
          cs_d        = 1'b1;
          case (req_op)
            OP_ACT: begin
              code_d   = {CA_ACT1_HDR, req_arg[3:0]};
              load_gap = 1'b1;
            end
            OP_PRE:  code_d = CA_PRE;
            OP_REF: begin
              if (gap_q == '0) begin
                code_d    = CA_REF;
                issue_ref = 1'b1;
              end else begin
                cs_d    = 1'b0;
                state_d = ST_GAP_WAIT;
              end
            end
            OP_WR16: code_d = CA_CAS_WR;
            OP_RD16: code_d = CA_CAS_RD;
            OP_MRW:  code_d = CA_MRW1;
            OP_MRR:  code_d = CA_MRR;
            OP_PDE:  code_d = CA_PDE;
            OP_PDX: begin
              code_d = CA_PDX;
              cs_d   = 1'b0;
            end
            default: begin
              cs_d  = 1'b0;
              err_d = 1'b1;
            end
          endcase
        end
      end
      ST_GAP_WAIT: begin
        if (gap_q == '0) begin
          code_d    = CA_REF;
          cs_d      = 1'b1;
          auto_d    = wait_auto_q;
          issue_ref = 1'b1;
          state_d   = ST_CMD1;
        end
      end
      ST_CMD1: begin
        state_d = ST_IDLE;
        case (op_q)
          OP_ACT: begin
            code_d  = {CA_ACT2_HDR, arg_q[7:4]};
            cs_d    = 1'b1;
            state_d = ST_CMD2;
          end
          OP_WR16: begin
            code_d  = {CA_WR2_HDR, arg_q[3:0]};
            cs_d    = 1'b1;
            state_d = ST_CMD2;
          end
          OP_RD16: begin
            code_d  = {CA_RD2_HDR, arg_q[3:0]};
            cs_d    = 1'b1;
            state_d = ST_CMD2;
          end
          OP_MRW: begin
            code_d  = {CA_MRW2_HDR, arg_q[0]};
            cs_d    = 1'b1;
            state_d = ST_CMD2;
          end
          OP_PDE: begin
            pd_d    = 1'b1;
            state_d = ST_PD;
          end
          default: ;
        endcase
      end
      ST_CMD2: state_d = ST_IDLE;
      ST_PD: begin
        pd_d = 1'b1;
        if (req_valid && (req_op == OP_PDX)) begin
          code_d  = CA_PDX;
          op_d    = OP_PDX;
          state_d = ST_CMD1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, captured request and registered bus outputs
  always_ff @(posedge ck_t or negedge ddr_reset_n) begin
    if (!ddr_reset_n) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      arg_q       <= '0;
      wait_auto_q <= 1'b0;
      ca          <= '0;
      cs          <= 1'b0;
      auto_ref    <= 1'b0;
      err         <= 1'b0;
      pd_active   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      arg_q       <= arg_d;
      wait_auto_q <= wait_auto_d;
      ca          <= ca_pins(code_d);
      cs          <= cs_d;
      auto_ref    <= auto_d;
      err         <= err_d;
      pd_active   <= pd_d;
    end
  end

  // ACT-to-REF gap: loaded on the ACT first cycle, counts down and rests at zero
  always_ff @(posedge ck_t or negedge ddr_reset_n) begin
    if (!ddr_reset_n) begin
      gap_q <= '0;
    end else if (load_gap) begin
      gap_q <= GW'(ACT_REF_GAP - 1);
    end else if (gap_q != '0) begin
      gap_q <= gap_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_gp_lpddr5_cmd_encoder.sv
// Self-checking bench for gp_lpddr5_cmd_encoder. Auto-refresh checks are
// compiled in when GP_LPDDR5_AUTO_REFRESH_EN is defined.
module tb_gp_lpddr5_cmd_encoder;
  import gp_lpddr5_cmd_pkg::*;

  localparam int PER = 10;
  localparam int GAP = 7;

  // Command codes as listed, CA0 first
  localparam logic [6:0] K_PRE = 7'b0001111;
  localparam logic [6:0] K_REF = 7'b0001110;
  localparam logic [6:0] K_CWR = 7'b0011100;
  localparam logic [6:0] K_CRD = 7'b0011010;
  localparam logic [6:0] K_MW1 = 7'b0001101;
  localparam logic [6:0] K_MRR = 7'b0001100;
  localparam logic [6:0] K_PDE = 7'b0000001;
  localparam logic [6:0] K_PDX = 7'b0000001;
  localparam logic [6:0] K_DES = 7'b0000000;

  logic       ck_t = 1'b0;
  logic       ddr_reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_op = 4'd0;
  logic [7:0] req_arg = 8'd0;
  logic [6:0] ca;
  logic       cs, auto_ref, pd_active, err;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_act = -1000;

  gp_lpddr5_cmd_encoder #(.REFI_CYC(64), .ACT_REF_GAP(GAP)) dut (
    .ck_t        (ck_t),
    .ddr_reset_n (ddr_reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_arg     (req_arg),
    .ca          (ca),
    .cs          (cs),
    .auto_ref    (auto_ref),
    .pd_active   (pd_active),
    .err         (err)
  );

  always #(PER/2) ck_t = ~ck_t;
  always @(posedge ck_t) cyc <= cyc + 1;

  initial begin
    #(50000 * PER);
    $display("FAIL watchdog: got no finish, expected finish before 50000 cycles");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] snap();
    return {auto_ref, err, pd_active, cs, ca};
  endfunction

  // Expected observable word; code is written CA0 first like the command table
  function automatic logic [10:0] wexp(input logic pd, input logic er, input logic au,
                                       input logic c, input logic [6:0] code);
    logic [6:0] pins;
    pins = {<<{code}};
    return {au, er, pd, c, pins};
  endfunction

  // Offer one request, wait for acceptance, then check every bus cycle it produces
  task automatic do_cmd(input logic [3:0] op, input logic [7:0] arg);
    logic [10:0] w[$];
    int          e, waits;
    logic        pd_after;
    @(negedge ck_t);
    req_valid = 1'b1;
    req_op    = op;
    req_arg   = arg;
    #1;
    waits = 0;
    while (!req_ready && waits < 200) begin
      @(negedge ck_t);
      #1;
      waits++;
    end
    check_eq("ready", 32'(req_ready), 32'd1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge ck_t);
    #1;
    e = cyc;
    req_valid = 1'b0;
    pd_after = 1'b0;
    case (op)
      OP_ACT: begin
        w.push_back(wexp(1'b0, 1'b0, 1'b0, 1'b1, {3'b111, arg[3:0]}));
        w.push_back(wexp(1'b0, 1'b0, 1'b0, 1'b1, {3'b110, arg[7:4]}));
        last_act = e;
      end
      OP_PRE:  w.push_back(wexp(1'b0, 1'b0, 1'b0, 1'b1, K_PRE));
      OP_REF: begin
        for (int k = 0; k < last_act + GAP - e; k++)
          w.push_back(wexp(1'b0, 1'b0, 1'b0, 1'b0, K_DES));
        w.push_back(wexp(1'b0, 1'b0, 1'b0, 1'b1, K_REF));
      end
      OP_WR16: begin
        w.push_back(wexp(1'b0, 1'b0, 1'b0, 1'b1, K_CWR));
        w.push_back(wexp(1'b0, 1'b0, 1'b0, 1'b1, {3'b011, arg[3:0]}));
      end
      OP_RD16: begin
        w.push_back(wexp(1'b0, 1'b0, 1'b0, 1'b1, K_CRD));
        w.push_back(wexp(1'b0, 1'b0, 1'b0, 1'b1, {3'b100, arg[3:0]}));
      end
      OP_MRW: begin
        w.push_back(wexp(1'b0, 1'b0, 1'b0, 1'b1, K_MW1));
        w.push_back(wexp(1'b0, 1'b0, 1'b0, 1'b1, {6'b000100, arg[0]}));
      end
      OP_MRR:  w.push_back(wexp(1'b0, 1'b0, 1'b0, 1'b1, K_MRR));
      OP_PDE: begin
        w.push_back(wexp(1'b0, 1'b0, 1'b0, 1'b1, K_PDE));
        pd_after = 1'b1;
      end
      OP_PDX:  w.push_back(wexp(1'b1, 1'b0, 1'b0, 1'b0, K_PDX));
      default: w.push_back(wexp(1'b0, 1'b1, 1'b0, 1'b0, K_DES));
    endcase
    foreach (w[i]) begin
      @(negedge ck_t);
      check_eq($sformatf("op%0d_arg%0h_cyc%0d", op, arg, i), 32'(snap()), 32'(w[i]));
    end
    @(negedge ck_t);
    check_eq($sformatf("op%0d_des_after", op), 32'(snap()), 32'(wexp(pd_after, 1'b0, 1'b0, 1'b0, K_DES)));
  endtask

  task automatic rand_traffic(input int n);
    int          r, idle;
    logic [3:0]  op;
    logic [7:0]  arg;
    for (int i = 0; i < n; i++) begin
      idle = $urandom_range(0, 3);
      repeat (idle) @(negedge ck_t);
      r   = $urandom_range(0, 10);
      arg = 8'($urandom);
      case (r)
        0, 9:    op = OP_ACT;
        1:       op = OP_PRE;
        2, 7:    op = OP_REF;
        3:       op = OP_WR16;
        4:       op = OP_RD16;
        5:       op = OP_MRW;
        6:       op = OP_MRR;
        8:       op = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(10, 15));
        default: op = OP_PDE;
      endcase
      do_cmd(op, arg);
      if (op == OP_PDE) begin
        repeat ($urandom_range(0, 4)) @(negedge ck_t);
        do_cmd(OP_PDX, 8'd0);
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge ck_t);
    ddr_reset_n = 1'b0;
    @(negedge ck_t);
    ddr_reset_n = 1'b1;
    last_act = -1000;
  endtask

`ifdef GP_LPDDR5_AUTO_REFRESH_EN
  logic mon_en = 1'b0;
  int   mon_last = -1;

  // Under traffic the spacing of REFs on the bus must stay bounded
  always @(negedge ck_t) begin
    if (mon_en && cs && (ca == 7'b0111000)) begin
      if (mon_last >= 0)
        check_eq("ref_interval_le100", 32'((cyc - mon_last) <= 100), 32'd1);
      mon_last = cyc;
    end
  end
`endif

  initial begin
    #(2*PER + 2);
    check_eq("rst_bus", 32'(snap()), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    @(negedge ck_t);
    ddr_reset_n = 1'b1;
    #1;
    check_eq("ready_after_rst", 32'(req_ready), 32'd1);

    // Directed command encodings and the ACT->REF gap
    do_cmd(OP_ACT, 8'hA5);
    do_cmd(OP_REF, 8'h00);
    do_cmd(OP_WR16, 8'h03);
    do_cmd(OP_RD16, 8'h0C);
    do_cmd(OP_MRW, 8'h01);
    do_cmd(OP_MRW, 8'h00);
    do_cmd(OP_MRR, 8'h00);
    do_cmd(OP_PRE, 8'h00);
    do_cmd(4'hF, 8'h00);
    do_cmd(4'h0, 8'h00);
    do_cmd(OP_REF, 8'h00);

    // Power-down entry, idle, blocked request, exit
    do_cmd(OP_PDE, 8'h00);
    repeat (20) begin
      @(negedge ck_t);
      check_eq("pd_idle", 32'(snap()), 32'(wexp(1'b1, 1'b0, 1'b0, 1'b0, K_DES)));
    end
    req_valid = 1'b1;
    req_op    = OP_RD16;
    req_arg   = 8'h05;
    repeat (3) begin
      #1;
      check_eq("pd_rd_ready", 32'(req_ready), 32'd0);
      @(negedge ck_t);
      check_eq("pd_rd_bus", 32'(snap()), 32'(wexp(1'b1, 1'b0, 1'b0, 1'b0, K_DES)));
    end
    req_valid = 1'b0;
    do_cmd(OP_PDX, 8'h00);

    // Reset in the middle of WR16
    @(negedge ck_t);
    req_valid = 1'b1;
    req_op    = OP_WR16;
    req_arg   = 8'h03;
    #1;
    check_eq("wr_ready", 32'(req_ready), 32'd1);
    @(posedge ck_t);
    #1;
    req_valid = 1'b0;
    @(negedge ck_t);
    check_eq("rst_wr_cas", 32'(snap()), 32'(wexp(1'b0, 1'b0, 1'b0, 1'b1, K_CWR)));
    ddr_reset_n = 1'b0;
    #1;
    check_eq("rst_async_bus", 32'(snap()), 32'd0);
    check_eq("rst_async_ready", 32'(req_ready), 32'd0);
    @(posedge ck_t);
    #1;
    check_eq("rst_hold_bus", 32'(snap()), 32'd0);
    @(negedge ck_t);
    ddr_reset_n = 1'b1;
    last_act = -1000;
    #1;
    check_eq("rst_release_ready", 32'(req_ready), 32'd1);
    @(posedge ck_t);
    #1;
    check_eq("rst_no_wr2", 32'(snap()), 32'd0);

    // Reset clears the ACT gap counter: REF goes out without waiting
    do_cmd(OP_ACT, 8'h3C);
    pulse_reset();
    do_cmd(OP_REF, 8'h00);

    rand_traffic(250);

`ifdef GP_LPDDR5_AUTO_REFRESH_EN
    begin
      int prev, nref;
      pulse_reset();
      prev = -1;
      nref = 0;
      for (int k = 1; k <= 300; k++) begin
        @(negedge ck_t);
        if (snap() == wexp(1'b0, 1'b0, 1'b1, 1'b1, K_REF)) begin
          if (prev < 0) check_eq("auto_first", 32'(k), 32'd65);
          else          check_eq("auto_interval", 32'(k - prev), 32'd65);
          prev = k;
          nref++;
        end
      end
      check_eq("auto_count", 32'(nref), 32'd4);
      mon_last = -1;
      mon_en   = 1'b1;
      rand_traffic(80);
      mon_en   = 1'b0;
    end
`else
    check_eq("auto_ref_off", 32'(auto_ref), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
